// File: rtl/line_follower_pkg.sv
// Shared types and defaults for the line follower drive path.
package line_follower_pkg;

    localparam int PWM_PERIOD_DEF = 1000;
    localparam int DUTY_W_DEF     = 11;
    localparam int BASE_DUTY_DEF  = 600;
    localparam int PID_W          = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_RUN  = 2'd2,
        ST_LOST = 2'd3
    } drive_state_t;

endpackage

// File: rtl/pwm_gen.sv
// Period counter, boundary strobe and the two registered duty comparators.
// The comparators look at next-cycle counter and duty so the pin lines up
// with the counter value it is shown against.
import line_follower_pkg::*;

module pwm_gen #(
    parameter int PWM_PERIOD = PWM_PERIOD_DEF,
    parameter int DUTY_W     = DUTY_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] duty_left_next,
    input  logic [DUTY_W-1:0] duty_right_next,
    output logic              boundary,
    output logic              pwm_left,
    output logic              pwm_right
);

    localparam int CNT_W = $clog2(PWM_PERIOD);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    assign boundary   = (count == CNT_W'(PWM_PERIOD - 1));
    assign count_next = boundary ? '0 : count + 1'b1;

    // Counter and pin registers; reset restarts the period with pins low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count     <= '0;
            pwm_left  <= 1'b0;
            pwm_right <= 1'b0;
        end else begin
            count     <= count_next;
            pwm_left  <= (32'(count_next) < 32'(duty_left_next));
            pwm_right <= (32'(count_next) < 32'(duty_right_next));
        end
    end

endmodule

// File: rtl/motor_pwm_mixer.sv
// Mixes the PID correction into left/right duties around a base speed and
// supervises the drive (soft start, run, line-lost stop, disable).
//
// state | meaning
// IDLE  | drive off, duties 0, waiting for enable
// RAMP  | soft start, base duty climbs by RAMP_STEP per period
// RUN   | base duty at BASE_DUTY, correction mixed in
// LOST  | line lost for LOST_PERIODS boundaries, duties 0, brake on
import line_follower_pkg::*;

module motor_pwm_mixer #(
    parameter int PWM_PERIOD   = PWM_PERIOD_DEF,
    parameter int DUTY_W       = DUTY_W_DEF,
    parameter int BASE_DUTY    = BASE_DUTY_DEF,
    parameter int RAMP_STEP    = 50,
    parameter int CORR_SHIFT   = 2,
    parameter int LOST_PERIODS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic signed [PID_W-1:0] pid_output,
    input  logic                    line_lost,
    output logic                    pwm_left,
    output logic                    pwm_right,
    output logic                    brake,
    output logic [DUTY_W-1:0]       duty_left,
    output logic [DUTY_W-1:0]       duty_right,
    output logic [1:0]              state
);

    localparam logic signed [15:0] PERIOD_S = 16'(PWM_PERIOD);

    drive_state_t      state_q, state_n;
    logic [DUTY_W-1:0] base_q, base_n;
    logic [DUTY_W-1:0] dl_q, dl_n, dr_q, dr_n;
    logic [3:0]        lost_q, lost_n;
    logic              boundary;

    // base +/- (pid >>> CORR_SHIFT) in 16-bit signed, clamped to [0, PWM_PERIOD].
    function automatic logic [DUTY_W-1:0] mix_duty(input logic [DUTY_W-1:0] base,
                                                    input logic [PID_W-1:0] pid,
                                                    input logic add);
        logic signed [15:0] corr;
        logic signed [15:0] base_s;
        logic signed [15:0] sum;
        corr   = signed'({{(16-PID_W){pid[PID_W-1]}}, pid}) >>> CORR_SHIFT;
        base_s = signed'({{(16-DUTY_W){1'b0}}, base});
        sum    = add ? (base_s + corr) : (base_s - corr);
        if (sum < 16'sd0)
            return '0;
        else if (sum > PERIOD_S)
            return DUTY_W'(PWM_PERIOD);
        else
            return DUTY_W'(sum);
    endfunction

    // Next-state, base and duty decisions; disable acts on any cycle.
    always_comb begin
        state_n = state_q;
        base_n  = base_q;
        lost_n  = lost_q;
        dl_n    = dl_q;
        dr_n    = dr_q;
        if (!enable) begin
            state_n = ST_IDLE;
            base_n  = '0;
            lost_n  = '0;
            dl_n    = '0;
            dr_n    = '0;
        end else if (boundary) begin
            case (state_q)
                ST_IDLE: begin
                    base_n  = '0;
                    dl_n    = '0;
                    dr_n    = '0;
                    state_n = ST_RAMP;
                end
                ST_RAMP: begin
                    if (32'(base_q) + RAMP_STEP >= BASE_DUTY) begin
                        base_n  = DUTY_W'(BASE_DUTY);
                        state_n = ST_RUN;
                    end else begin
                        base_n = base_q + DUTY_W'(RAMP_STEP);
                    end
                    dl_n = mix_duty(base_n, pid_output, 1'b1);
                    dr_n = mix_duty(base_n, pid_output, 1'b0);
                end
                ST_RUN: begin
                    base_n = DUTY_W'(BASE_DUTY);
                    dl_n   = mix_duty(base_n, pid_output, 1'b1);
                    dr_n   = mix_duty(base_n, pid_output, 1'b0);
                    if (!line_lost) begin
                        lost_n = '0;
                    end else if (32'(lost_q) >= LOST_PERIODS - 1) begin
                        state_n = ST_LOST;
                        lost_n  = '0;
                        base_n  = '0;
                        dl_n    = '0;
                        dr_n    = '0;
                    end else begin
                        lost_n = lost_q + 4'd1;
                    end
                end
                ST_LOST: begin
                    base_n = '0;
                    dl_n   = '0;
                    dr_n   = '0;
                    if (!line_lost)
                        state_n = ST_RAMP;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // State, base speed, line-lost count and active duty registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            lost_q  <= '0;
            dl_q    <= '0;
            dr_q    <= '0;
        end else begin
            state_q <= state_n;
            base_q  <= base_n;
            lost_q  <= lost_n;
            dl_q    <= dl_n;
            dr_q    <= dr_n;
        end
    end

    pwm_gen #(
        .PWM_PERIOD (PWM_PERIOD),
        .DUTY_W     (DUTY_W)
    ) u_pwm_gen (
        .clk             (clk),
        .rst             (rst),
        .duty_left_next  (dl_n),
        .duty_right_next (dr_n),
        .boundary        (boundary),
        .pwm_left        (pwm_left),
        .pwm_right       (pwm_right)
    );

    assign duty_left  = dl_q;
    assign duty_right = dr_q;
    assign brake      = (state_q == ST_LOST);
    assign state      = state_q;

endmodule
